// File: rtl/vector_fp_pkg.sv
// Shared types and double-precision field constants for the vector int-to-FP path.
package vector_fp_pkg;

    localparam int DP_EXP_WIDTH  = 11;
    localparam int DP_EXP_BIAS   = 1023;
    localparam int DP_MANT_WIDTH = 52;

    typedef struct packed {
        logic                     sign;
        logic [DP_EXP_WIDTH-1:0]  exponent;
        logic [DP_MANT_WIDTH-1:0] mantissa;
        logic                     zero;
        logic                     inexact;
    } fp_result_t;

endpackage

// File: rtl/leading_zeroes_counter.sv
// Leading-zero count of an unsigned word; the output for an all-zero word is not meaningful.
module leading_zeroes_counter #(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0]  data,
    output logic [COUNT_WIDTH-1:0] count
);

    logic found;

    always_comb begin
        count = '0;
        found = 1'b0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (data[i]) found = 1'b1;
                else         count = count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/vector_pipe_stage.sv
// Generic valid/ready register slice: loads whenever empty or draining downstream.
module vector_pipe_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Data only moves on a real transfer, so a stalled output never changes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) data_q <= in_data;
        end
    end

endmodule

// File: rtl/vector_int_to_fp_normalizer.sv
// Two-stage integer-to-FP front end: sign/magnitude, then LZC-driven normalization.
// Define VECTOR_INT_TO_FP_NORMALIZER_RNE_EN for round-to-nearest-even; default truncates.
module vector_int_to_fp_normalizer
    import vector_fp_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = $clog2(DATA_WIDTH),
    parameter int EXP_WIDTH   = DP_EXP_WIDTH,
    parameter int EXP_BIAS    = DP_EXP_BIAS,
    parameter int MANT_WIDTH  = DP_MANT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [EXP_WIDTH-1:0]  out_exponent,
    output logic [MANT_WIDTH-1:0] out_mantissa,
    output logic                  out_zero,
    output logic                  out_inexact
);

    localparam int S1_W = DATA_WIDTH + 2;
    localparam int S2_W = EXP_WIDTH + MANT_WIDTH + 3;
    localparam int DROP = DATA_WIDTH - 1 - MANT_WIDTH;
    localparam logic [EXP_WIDTH:0] EXP_TOP = (EXP_WIDTH+1)'(EXP_BIAS + DATA_WIDTH - 1);

    // Stage 1: sign and magnitude
    logic                  s1_sign, s1_zero;
    logic [DATA_WIDTH-1:0] s1_mag;
    logic [S1_W-1:0]       s1_q;
    logic                  s1_valid, s2_in_ready;

    assign s1_sign = in_signed & in_data[DATA_WIDTH-1];
    assign s1_mag  = s1_sign ? (~in_data + DATA_WIDTH'(1)) : in_data;
    assign s1_zero = ~|in_data;

    vector_pipe_stage #(.WIDTH(S1_W)) u_stage1 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({s1_sign, s1_mag, s1_zero}),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_q)
    );

    // Stage 2: normalization
    logic                   st1_sign, st1_zero;
    logic [DATA_WIDTH-1:0]  st1_mag, shifted;
    logic [COUNT_WIDTH-1:0] lz_count;
    logic [EXP_WIDTH:0]     exp_full, exp_rnd;
    logic [MANT_WIDTH-1:0]  frac_trunc, frac_out;
    logic                   inexact;
    logic [S2_W-1:0]        s2_d, s2_q;

    assign {st1_sign, st1_mag, st1_zero} = s1_q;

    leading_zeroes_counter #(.DATA_WIDTH(DATA_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) u_lzc (
        .data  (st1_mag),
        .count (lz_count)
    );

    assign shifted    = st1_mag << lz_count;
    assign exp_full   = EXP_TOP - (EXP_WIDTH+1)'(lz_count);
    assign frac_trunc = shifted[DATA_WIDTH-2 -: MANT_WIDTH];

    generate
        if (DROP == 0) begin : g_exact
            assign inexact = 1'b0;
        end else begin : g_drop
            assign inexact = |shifted[DROP-1:0];
        end
    endgenerate

`ifdef VECTOR_INT_TO_FP_NORMALIZER_RNE_EN
    logic                round_up;
    logic [MANT_WIDTH:0] frac_sum;

    generate
        if (DROP == 0) begin : g_rnd_none
            assign round_up = 1'b0;
        end else if (DROP == 1) begin : g_rnd_guard
            assign round_up = shifted[0] & frac_trunc[0];
        end else begin : g_rnd_full
            assign round_up = shifted[DROP-1] & ((|shifted[DROP-2:0]) | frac_trunc[0]);
        end
    endgenerate

    // A carry-out leaves the low bits zero, which is exactly the renormalized fraction.
    assign frac_sum = {1'b0, frac_trunc} + (MANT_WIDTH+1)'(round_up);
    assign frac_out = frac_sum[MANT_WIDTH-1:0];
    assign exp_rnd  = exp_full + (EXP_WIDTH+1)'(frac_sum[MANT_WIDTH]);
`else
    assign frac_out = frac_trunc;
    assign exp_rnd  = exp_full;
`endif

    logic [1:0] unused_bits;
    assign unused_bits = {shifted[DATA_WIDTH-1], exp_rnd[EXP_WIDTH]};

    // Zero input: the counter output is meaningless, so force the fields.
    assign s2_d = {st1_sign,
                   st1_zero ? '0 : exp_rnd[EXP_WIDTH-1:0],
                   st1_zero ? '0 : frac_out,
                   st1_zero,
                   st1_zero ? 1'b0 : inexact};

    vector_pipe_stage #(.WIDTH(S2_W)) u_stage2 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign {out_sign, out_exponent, out_mantissa, out_zero, out_inexact} = s2_q;

endmodule

// File: tb/tb_vector_int_to_fp_normalizer.sv
// Directed bench for vector_int_to_fp_normalizer (64-bit int -> double fields).
module tb_vector_int_to_fp_normalizer;
    import vector_fp_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_signed;
    logic [63:0] in_data;
    logic        out_valid, out_ready;
    logic        out_sign, out_zero, out_inexact;
    logic [10:0] out_exponent;
    logic [51:0] out_mantissa;

    int checks = 0;
    int errors = 0;

    vector_int_to_fp_normalizer dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_signed    (in_signed),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exponent (out_exponent),
        .out_mantissa (out_mantissa),
        .out_zero     (out_zero),
        .out_inexact  (out_inexact)
    );

    always #5 clock = ~clock;

    function automatic fp_result_t cur();
        return fp_result_t'{out_sign, out_exponent, out_mantissa, out_zero, out_inexact};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated element with out_ready=1: accepted, absent after 1 cycle, present after 2.
    task automatic single(input string tag, input logic [63:0] d, input logic sg, input fp_result_t e);
        @(negedge clock);
        in_valid = 1'b1; in_data = d; in_signed = sg;
        #1 chk({tag, "_rdy"}, 128'(in_ready), 128'(1'b1));
        @(negedge clock);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 128'(out_valid), 128'(1'b0));
        @(negedge clock);
        chk({tag, "_vld"}, 128'(out_valid), 128'(1'b1));
        chk(tag, 128'(cur()), 128'(e));
    endtask

    logic [63:0] bp_d [5];
    fp_result_t  bp_e [5];
    fp_result_t  prev;
    logic        have_prev;
    int          sent, recv, last_rx, stale;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b1;

        repeat (2) @(negedge clock);
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_out_data", 128'(cur()), 128'(0));
        reset = 1'b0;
        #1 chk("rst_in_ready", 128'(in_ready), 128'(1'b1));

        single("u1",      64'd1, 1'b0, fp_result_t'{1'b0, 11'd1023, 52'd0, 1'b0, 1'b0});
        single("u3",      64'd3, 1'b0, fp_result_t'{1'b0, 11'd1024, 52'h8_0000_0000_0000, 1'b0, 1'b0});
        single("u0",      64'd0, 1'b0, fp_result_t'{1'b0, 11'd0, 52'd0, 1'b1, 1'b0});
        single("s_m1",    64'hFFFF_FFFF_FFFF_FFFF, 1'b1, fp_result_t'{1'b1, 11'd1023, 52'd0, 1'b0, 1'b0});
        single("s_min",   64'h8000_0000_0000_0000, 1'b1, fp_result_t'{1'b1, 11'd1086, 52'd0, 1'b0, 1'b0});
        single("s_p5",    64'd5, 1'b1, fp_result_t'{1'b0, 11'd1025, 52'h4_0000_0000_0000, 1'b0, 1'b0});
        single("u_tie_e", 64'h0020_0000_0000_0001, 1'b0, fp_result_t'{1'b0, 11'd1076, 52'd0, 1'b0, 1'b1});
`ifdef VECTOR_INT_TO_FP_NORMALIZER_RNE_EN
        single("u_max",   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, fp_result_t'{1'b0, 11'd1087, 52'd0, 1'b0, 1'b1});
        single("u_tie_o", 64'h0020_0000_0000_0003, 1'b0, fp_result_t'{1'b0, 11'd1076, 52'd2, 1'b0, 1'b1});
`else
        single("u_max",   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, fp_result_t'{1'b0, 11'd1086, {52{1'b1}}, 1'b0, 1'b1});
        single("u_tie_o", 64'h0020_0000_0000_0003, 1'b0, fp_result_t'{1'b0, 11'd1076, 52'd1, 1'b0, 1'b1});
`endif

        // Backpressure: 5 back-to-back elements, out_ready low for the first 4 cycles.
        bp_d[0] = 64'd1; bp_e[0] = fp_result_t'{1'b0, 11'd1023, 52'd0, 1'b0, 1'b0};
        bp_d[1] = 64'd2; bp_e[1] = fp_result_t'{1'b0, 11'd1024, 52'd0, 1'b0, 1'b0};
        bp_d[2] = 64'd3; bp_e[2] = fp_result_t'{1'b0, 11'd1024, 52'h8_0000_0000_0000, 1'b0, 1'b0};
        bp_d[3] = 64'd4; bp_e[3] = fp_result_t'{1'b0, 11'd1025, 52'd0, 1'b0, 1'b0};
        bp_d[4] = 64'd5; bp_e[4] = fp_result_t'{1'b0, 11'd1025, 52'h4_0000_0000_0000, 1'b0, 1'b0};
        sent = 0; recv = 0; last_rx = -1; have_prev = 1'b0; prev = '0;
        @(negedge clock);
        for (int c = 0; c < 12; c++) begin
            out_ready = (c >= 4);
            in_signed = 1'b0;
            in_valid  = (sent < 5);
            in_data   = (sent < 5) ? bp_d[sent] : 64'd0;
            #1;
            if (c == 2) chk("bp_in_ready_drop", 128'(in_ready), 128'(1'b0));
            if (out_valid && !out_ready) begin
                if (have_prev) chk("bp_hold", 128'(cur()), 128'(prev));
                prev = cur(); have_prev = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (recv < 5) chk($sformatf("bp_out%0d", recv), 128'(cur()), 128'(bp_e[recv]));
                else          chk("bp_extra", 128'(out_valid), 128'(1'b0));
                recv++; last_rx = c;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clock);
        end
        chk("bp_count", 128'(recv), 128'(5));
        chk("bp_last_cycle", 128'(last_rx), 128'(8));

        // Reset with two elements in flight.
        out_ready = 1'b1; in_signed = 1'b0;
        in_valid = 1'b1; in_data = 64'd7;
        @(negedge clock);
        in_data = 64'd9;
        @(negedge clock);
        in_valid = 1'b0;
        #1 chk("rst_pre_valid", 128'(out_valid), 128'(1'b1));
        #1 reset = 1'b1;
        #1 chk("rst_async_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_async_data", 128'(cur()), 128'(0));
        @(negedge clock);
        reset = 1'b0;
        #1 chk("rst_rel_ready", 128'(in_ready), 128'(1'b1));
        stale = 0;
        repeat (6) begin
            @(negedge clock);
            #1 if (out_valid) stale++;
        end
        chk("rst_no_stale", 128'(stale), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_int_to_fp_normalizer.md
Name: vector_int_to_fp_normalizer

Overview:
- Two-stage pipelined front end for vector integer-to-floating-point conversion.
- Takes one integer element per cycle and produces sign, biased exponent and normalized fraction.
- Sits directly downstream of the leading-zero count. It instantiates the existing leading_zeroes_counter on the registered magnitude and consumes its count to drive the normalizing shift.
- Output feeds the FP result packer over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 64, integer element width; power of two, >= 4.
- COUNT_WIDTH, $clog2(DATA_WIDTH), leading-zero count width.
- EXP_WIDTH, 11, exponent field width.
- EXP_BIAS, 1023, exponent bias.
- MANT_WIDTH, 52, stored fraction width (hidden bit excluded); must be <= DATA_WIDTH-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input element valid.
- in_ready  output  1  normalizer accepts the element this cycle.
- in_data  input  DATA_WIDTH  integer element.
- in_signed  input  1  1: in_data is two's complement; 0: unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sign  output  1  result sign.
- out_exponent  output  EXP_WIDTH  biased exponent.
- out_mantissa  output  MANT_WIDTH  normalized fraction.
- out_zero  output  1  input was zero.
- out_inexact  output  1  nonzero bits were lost below the fraction LSB.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: both stage valid flags and all data registers are 0. Therefore out_valid=0 and the out_* data outputs are 0. in_ready=1 from the first cycle after reset deassertion.
- Reset mid-operation: in-flight elements are discarded, not completed.
- Handshake: a transfer occurs when valid && ready on the same edge. Stage k advances when it is empty or its downstream transfer completes: ready_k = !valid_k || ready_{k+1}. in_ready = ready_1, combinational; no combinational path from in_valid to in_ready.
- Throughput and latency: one element per cycle sustained. With out_ready held at 1, the result appears 2 cycles after the input transfer.
- Ordering: results leave in input order; no drops or duplicates under any out_ready pattern.
- Stage 1 (sign and magnitude):
  - sign = in_signed & in_data[DATA_WIDTH-1].
  - magnitude = sign ? (~in_data + 1) : in_data, held unsigned in DATA_WIDTH bits, so the most negative value maps to 2^(DATA_WIDTH-1).
  - zero = ~|in_data.
- Stage 2 (normalization):
  - count = leading_zeroes_counter(magnitude).
  - shifted = magnitude << count.
  - exponent = EXP_BIAS + DATA_WIDTH-1 - count, computed in EXP_WIDTH+1 bits and truncated to EXP_WIDTH.
  - fraction = shifted[DATA_WIDTH-2 -: MANT_WIDTH].
  - inexact = |shifted[DATA_WIDTH-2-MANT_WIDTH:0], or 0 when that range is empty.
- Zero input: the counter's all-zero output is not meaningful. Force exponent=0, mantissa=0, inexact=0 and zero=1; the sign is preserved (always 0 for a zero integer).
- Hold under stall: while out_valid=1 and out_ready=0, all out_* signals stay stable.

Optional Feature:
- VECTOR_INT_TO_FP_NORMALIZER_RNE_EN defined: stage 2 rounds to nearest, ties to even.
  - guard = first dropped bit; sticky = OR of the remaining dropped bits.
  - Increment the fraction when guard && (sticky || fraction LSB).
  - On fraction carry-out, mantissa=0 and exponent+1.
  - out_inexact is unchanged: it still reports any dropped nonzero bit.
  - Latency stays 2 cycles.
- Undefined: truncation (round toward zero); no incrementer is instantiated.

Decomposition:
- Package vector_fp_pkg holds:
  - typedef fp_result_t {sign, exponent, mantissa, zero, inexact};
  - constants DP_EXP_WIDTH=11, DP_EXP_BIAS=1023, DP_MANT_WIDTH=52.
- Sub-modules:
  - Reuse the existing leading_zeroes_counter; no new counter.
  - One new sub-module is natural: vector_pipe_stage, a generic valid/ready register slice instantiated twice.

Test Plan:
- Unsigned in_data=1 -> sign=0, exponent=1023, mantissa=0, zero=0, inexact=0; arrives 2 cycles after acceptance.
- Unsigned in_data=3 -> exponent=1024, mantissa=1<<51. Unsigned in_data=0 -> zero=1, exponent=0, mantissa=0.
- Signed in_data=all-ones (-1) -> sign=1, exponent=1023, mantissa=0. Signed 0x8000_0000_0000_0000 -> sign=1, exponent=1086, mantissa=0.
- Unsigned 0xFFFF_FFFF_FFFF_FFFF:
  - macro undefined -> exponent=1086, mantissa=all 52 ones, inexact=1;
  - macro defined -> exponent=1087, mantissa=0, inexact=1.
- Backpressure: feed 5 back-to-back elements with out_ready=0 for 4 cycles.
  - in_ready drops after 2 elements are held.
  - out_* stay stable while stalled.
  - After out_ready=1, all 5 results emerge in order at 1 per cycle.
- Assert reset with 2 elements in flight -> out_valid=0 asynchronously; in_ready=1 after release; no stale result ever appears.
